tw_seq_gen: RTL and testbench
=============================

# tw_seq_gen

Twiddle-sequence initiator for the 8-point NTT datapath. It generates the powers w^0 … w^(N_PTS-1) of the primitive N_PTS-th root of unity mod Q. For each power it sends the raw product (previous twiddle × ROOT) to the modular reducer over a request/done handshake and captures the reduced result into an internal table. It then streams the table to the butterfly scheduler over a valid/ready interface. It sits on the requesting side of the mod-Q reducer: it drives the operand and consumes that unit's completion pulse.

## Interface
- N_PTS, 8, number of twiddles; must be a power of two, at most 16
- n, 25, reducer operand width (bits)
- Q, 3329, modulus
- ROOT, 2580, primitive N_PTS-th root of unity mod Q (17^32 mod 3329)
- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- gen_start  in  1  one-cycle pulse; accepted only in IDLE
- red_req  out  1  reducer request; high for exactly one cycle per operand
- red_op  out  n  operand (cur × ROOT); stable from red_req until red_done
- red_done  in  1  reducer completion pulse (the reducer's tw_ack)
- red_res  in  n  reduced value; sampled only in the red_done cycle
- tw_valid  out  1  stream data valid
- tw_ready  in  1  downstream accept
- tw_data  out  12  twiddle value
- tw_idx  out  $clog2(N_PTS)  exponent k of tw_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last stream beat
- err  out  1  sticky: red_res ≥ Q observed; cleared only by reset

## Operation
- States: IDLE, MUL, WAIT, STREAM.
- IDLE + gen_start: table[0] ← 1, cur ← 1, k ← 1; go to MUL. gen_start is ignored in any other state.
- MUL (one cycle): red_req = 1, red_op = cur × ROOT. The product is zero-extended to n bits and is always < 2^24. Go to WAIT.
- WAIT: red_op is held. On red_done: table[k] ← red_res[11:0], cur ← red_res.
  - If k = N_PTS-1: rd_ptr ← 0, go to STREAM.
  - Otherwise: k ← k+1, go to MUL.
- red_done outside WAIT (including the MUL cycle) is ignored.
- red_done with red_res ≥ Q sets err. The value is still stored and generation continues.
- STREAM: tw_valid = 1, tw_idx = addr, tw_data = table[addr].
  - On tw_valid & tw_ready: rd_ptr ← rd_ptr+1.
  - On the beat with rd_ptr = N_PTS-1: done pulses in the following cycle and the FSM returns to IDLE.
- tw_data and tw_idx must hold while tw_valid & !tw_ready.
- Table contents persist across runs. Every run regenerates all entries.

## Timing
- Reset values:
  - state = IDLE
  - red_req = tw_valid = busy = done = err = 0
  - red_op = 0, tw_data = 0, tw_idx = 0
  - k = rd_ptr = 0
- Reset in any state aborts the run in the same edge. A red_done arriving afterwards is ignored.
- L = cycles from red_req high to red_done high, with L ≥ 1.
- Per-twiddle generation cost is 1 + L cycles.
- First tw_valid appears (N_PTS-1)(1+L) + 1 cycles after the gen_start cycle.
- With tw_ready held high, streaming takes N_PTS cycles; done follows one cycle after the last beat.
- red_req is decoded from the state register: glitch-free and high for one cycle.

## Configuration
- TW_BITREV_EN defined: addr = bit-reverse of rd_ptr over $clog2(N_PTS) bits. For N_PTS = 8 the order is 0,4,2,6,1,5,3,7. tw_idx reports the reversed index.
- TW_BITREV_EN undefined: addr = rd_ptr, natural order 0…N_PTS-1.
- The generation phase is identical in both builds.

## Structure
- Package tw_pkg: Q, ROOT default, state enum (IDLE, MUL, WAIT, STREAM), and a bit-reverse function.
- One sub-module, tw_table:
  - N_PTS × 12 register file
  - one synchronous write port (we, waddr, wdata)
  - one combinational read port
  - no reset on the storage

## Test plan
- Natural order, L = 3 stub reducer, tw_ready = 1.
  - Stream is 1, 2580, 1729, 3289, 3328, 749, 1600, 40 with tw_idx 0…7.
  - done pulses once.
  - First tw_valid appears 29 cycles after gen_start.
- TW_BITREV_EN build, same stimulus.
  - Order is 1, 3328, 1729, 1600, 2580, 749, 3289, 40.
  - tw_idx is 0, 4, 2, 6, 1, 5, 3, 7.
- Backpressure: tw_ready toggles 1/0 each cycle.
  - Data is held while stalled; streaming takes 16 cycles; no beat is lost or duplicated.
- Handshake robustness:
  - red_done is injected during MUL and during STREAM; both are ignored.
  - gen_start is injected while busy; it is ignored.
  - red_op stays constant throughout WAIT.
- Reset mid-operation: reset asserted in WAIT with k = 4.
  - Next cycle: IDLE, all outputs at reset values.
  - A later red_done causes no write.
  - A fresh gen_start gives the correct full sequence.
- Error flag: the stub returns 3329 for k = 2.
  - err rises in that cycle and stays high through done.
  - A subsequent clean run leaves err = 1 until reset.

Source files
------------

// File: rtl/tw_pkg.sv
// Shared constants, FSM state type and bit-reverse helper for the twiddle generator.
package tw_pkg;

  localparam int TW_W    = 12;
  localparam int TW_Q    = 3329;
  localparam int TW_ROOT = 2580;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } tw_state_e;

  // Reverses the low `bits` bits of v; higher bits of the result are zero.
  function automatic logic [3:0] bitrev(input logic [3:0] v, input int bits);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < bits) r[bits-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tw_table.sv
// Twiddle storage: one synchronous write port, one combinational read port, no reset.
module tw_table #(
  parameter int DEPTH = 8,
  parameter int W     = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tw_seq_gen.sv
// Twiddle-sequence generator: builds w^0..w^(N_PTS-1) through an external mod-Q reducer, then streams them.
// Define TW_BITREV_EN to stream in bit-reversed index order instead of natural order.
module tw_seq_gen
  import tw_pkg::*;
#(
  parameter int N_PTS = 8,
  parameter int n     = 25,
  parameter int Q     = TW_Q,
  parameter int ROOT  = TW_ROOT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      gen_start,
  output logic                      red_req,
  output logic [n-1:0]              red_op,
  input  logic                      red_done,
  input  logic [n-1:0]              red_res,
  output logic                      tw_valid,
  input  logic                      tw_ready,
  output logic [TW_W-1:0]           tw_data,
  output logic [$clog2(N_PTS)-1:0]  tw_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int            IW     = $clog2(N_PTS);
  localparam logic [IW-1:0] K_LAST = IW'(N_PTS - 1);
  localparam logic [n-1:0]  ROOT_N = n'(ROOT);
  localparam logic [n-1:0]  Q_N    = n'(Q);

  tw_state_e         state_reg;
  logic [IW-1:0]     k_reg;
  logic [IW-1:0]     rd_ptr_reg;
  logic [n-1:0]      red_op_reg;
  logic              tw_valid_reg;
  logic [TW_W-1:0]   tw_data_reg;
  logic [IW-1:0]     tw_idx_reg;
  logic              done_reg;
  logic              err_reg;

  logic              tbl_we;
  logic [IW-1:0]     tbl_waddr;
  logic [TW_W-1:0]   tbl_wdata;
  logic [IW-1:0]     ptr_next;
  logic [IW-1:0]     tbl_raddr;
  logic [TW_W-1:0]   tbl_rdata;

  function automatic logic [IW-1:0] addr_of(input logic [IW-1:0] p);
`ifdef TW_BITREV_EN
    logic [3:0] t;
    t = bitrev(4'(p), IW);
    return t[IW-1:0];
`else
    return p;
`endif
  endfunction

  // Table write: entry 0 is seeded with 1 at start, the rest come from reducer completions.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    if (state_reg == IDLE && gen_start) begin
      tbl_we    = 1'b1;
      tbl_wdata = TW_W'(1);
    end else if (state_reg == WAIT && red_done) begin
      tbl_we    = 1'b1;
      tbl_waddr = k_reg;
      tbl_wdata = red_res[TW_W-1:0];
    end
  end

  // Read address looks one beat ahead so the stream outputs can be registered.
  always_comb begin
    ptr_next  = (state_reg == STREAM) ? rd_ptr_reg + IW'(1) : '0;
    tbl_raddr = addr_of(ptr_next);
  end

  tw_table #(
    .DEPTH (N_PTS),
    .W     (TW_W),
    .AW    (IW)
  ) u_table (
    .clock (clock),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .raddr (tbl_raddr),
    .rdata (tbl_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      rd_ptr_reg   <= '0;
      red_op_reg   <= '0;
      tw_valid_reg <= 1'b0;
      tw_data_reg  <= '0;
      tw_idx_reg   <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (gen_start) begin
            // cur = 1, so the first operand is ROOT itself.
            red_op_reg <= ROOT_N;
            k_reg      <= IW'(1);
            state_reg  <= MUL;
          end
        end
        MUL: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (red_done) begin
            if (red_res >= Q_N) err_reg <= 1'b1;
            if (k_reg == K_LAST) begin
              rd_ptr_reg   <= '0;
              tw_valid_reg <= 1'b1;
              tw_idx_reg   <= tbl_raddr;
              tw_data_reg  <= tbl_rdata;
              state_reg    <= STREAM;
            end else begin
              k_reg      <= k_reg + IW'(1);
              red_op_reg <= red_res * ROOT_N;
              state_reg  <= MUL;
            end
          end
        end
        STREAM: begin
          if (tw_ready) begin
            rd_ptr_reg <= ptr_next;
            if (rd_ptr_reg == K_LAST) begin
              tw_valid_reg <= 1'b0;
              tw_data_reg  <= '0;
              tw_idx_reg   <= '0;
              done_reg     <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              tw_idx_reg  <= tbl_raddr;
              tw_data_reg <= tbl_rdata;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign red_req  = (state_reg == MUL);
  assign busy     = (state_reg != IDLE);
  assign red_op   = red_op_reg;
  assign tw_valid = tw_valid_reg;
  assign tw_data  = tw_data_reg;
  assign tw_idx   = tw_idx_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_tw_seq_gen.sv
// Scoreboard bench for tw_seq_gen with an L=3 reducer stub; honours TW_BITREV_EN for expected order.
module tb_tw_seq_gen;

  localparam int L = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        gen_start;
  logic        red_req;
  logic [24:0] red_op;
  logic        red_done;
  logic [24:0] red_res;
  logic        tw_valid;
  logic        tw_ready;
  logic [11:0] tw_data;
  logic [2:0]  tw_idx;
  logic        busy;
  logic        done;
  logic        err;

  logic        stub_done, inj_done;
  logic [24:0] stub_res, inj_res;
  assign red_done = stub_done | inj_done;
  assign red_res  = inj_done ? inj_res : stub_res;

  tw_seq_gen dut (
    .clock     (clock),
    .reset     (reset),
    .gen_start (gen_start),
    .red_req   (red_req),
    .red_op    (red_op),
    .red_done  (red_done),
    .red_res   (red_res),
    .tw_valid  (tw_valid),
    .tw_ready  (tw_ready),
    .tw_data   (tw_data),
    .tw_idx    (tw_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] data;
    logic [2:0]  idx;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;
  int    done_cnt  = 0;
  int    valid_cyc = 0;
  bit    bp_mode = 0;
  int    bad_k   = -1;
  int    stub_k  = 0;
  bit    stub_busy = 0;

  logic [11:0] good_tbl [8] = '{12'd1, 12'd2580, 12'd1729, 12'd3289, 12'd3328, 12'd749, 12'd1600, 12'd40};
  logic [11:0] bad_tbl  [8] = '{12'd1, 12'd2580, 12'd3329, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
`ifdef TW_BITREV_EN
  logic [2:0]  ord [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
  logic [2:0]  ord [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_run(input bit bad);
    beat_t e;
    for (int i = 0; i < 8; i++) begin
      e.idx  = ord[i];
      e.data = bad ? bad_tbl[ord[i]] : good_tbl[ord[i]];
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_red_req", 32'(red_req), 0);
    check("rst_red_op", 32'(red_op), 0);
    check("rst_tw_valid", 32'(tw_valid), 0);
    check("rst_tw_data", 32'(tw_data), 0);
    check("rst_tw_idx", 32'(tw_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
  endtask

  // One full generate+stream run; optional latency check and handshake-robustness injections.
  task automatic run_gen(input bit bad, input bit bp, input bit meas_lat, input bit robust);
    int lat, d0, v0, guard;
    bit found;
    push_run(bad);
    bp_mode = bp;
    d0 = done_cnt;
    v0 = valid_cyc;
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    if (robust) begin
      inj_res  = 25'd999;
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      tick();
      gen_start = 1'b1;
      tick();
      gen_start = 1'b0;
    end
    found = 0;
    lat = 1;
    while (!found && lat < 400) begin
      @(negedge clock);
      if (tw_valid) found = 1;
      else lat++;
    end
    if (!found) check("first_valid_timeout", 0, 1);
    if (meas_lat) check("first_valid_latency", 32'(lat), 29);
    if (robust) begin
      tick();
      inj_res  = 25'd5;
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
    end
    found = 0;
    guard = 0;
    while (!found && guard < 400) begin
      @(negedge clock);
      if (done) found = 1;
      else guard++;
    end
    if (!found) check("done_timeout", 0, 1);
    repeat (3) tick();
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("beats_left", 32'(exp_q.size()), 0);
    check("valid_cycles", 32'(valid_cyc - v0), bp ? 16 : 8);
    exp_q.delete();
    bp_mode = 0;
  endtask

  // Reducer stub: answers each request L cycles later and checks the operand.
  initial begin : stub
    logic [24:0] op, res;
    int unsigned cur;
    stub_done = 1'b0;
    stub_res  = '0;
    cur = 1;
    forever begin
      @(negedge clock);
      if (gen_start && !busy) begin
        stub_k = 0;
        cur = 1;
      end
      if (red_req) begin
        stub_k++;
        stub_busy = 1;
        op = red_op;
        check("red_op_value", 32'(red_op), 32'(cur * 2580));
        for (int i = 0; i < L; i++) begin
          tick();
          if (busy) check("red_op_hold", 32'(red_op), 32'(op));
        end
        res = (stub_k == bad_k) ? 25'd3329 : op % 25'd3329;
        stub_res  = res;
        stub_done = 1'b1;
        tick();
        stub_done = 1'b0;
        cur = 32'(res);
        if (res >= 25'd3329) check("err_rise", 32'(err), 1);
        stub_busy = 0;
      end
    end
  end

  // Downstream ready: constant high, or alternating 0/1 starting low on the first valid cycle.
  initial begin : ready_drv
    tw_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      tw_ready = bp_mode ? (tw_valid ? ~tw_ready : 1'b1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each accepted beat and checks stalled data is held.
  initial begin : monitor
    beat_t       e;
    bit          held_v = 0;
    logic [11:0] held_data = '0;
    logic [2:0]  held_idx = '0;
    forever begin
      @(negedge clock);
      if (done) done_cnt++;
      if (tw_valid) valid_cyc++;
      if (held_v && tw_valid) begin
        check("hold_data", 32'(tw_data), 32'(held_data));
        check("hold_idx", 32'(tw_idx), 32'(held_idx));
      end
      held_v    = tw_valid && !tw_ready;
      held_data = tw_data;
      held_idx  = tw_idx;
      if (tw_valid && tw_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(tw_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tw_data", 32'(tw_data), 32'(e.data));
          check("tw_idx", 32'(tw_idx), 32'(e.idx));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int guard;
    reset     = 1'b1;
    gen_start = 1'b0;
    inj_done  = 1'b0;
    inj_res   = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs();
    tick();

    run_gen(0, 0, 1, 0);
    run_gen(0, 1, 0, 0);
    run_gen(0, 0, 0, 1);

    // Abort in WAIT with k = 4; the stub's late completion must be ignored.
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    guard = 0;
    while (!(stub_k == 4 && stub_busy) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("reach_k4_timeout", 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs();
    repeat (8) tick();
    check("post_abort_busy", 32'(busy), 0);
    check("post_abort_valid", 32'(tw_valid), 0);
    run_gen(0, 0, 1, 0);

    // Out-of-range result at k = 2 sets err, which stays sticky until reset.
    check("err_before_bad", 32'(err), 0);
    bad_k = 2;
    run_gen(1, 0, 1, 0);
    check("err_after_bad", 32'(err), 1);
    bad_k = -1;
    run_gen(0, 0, 1, 0);
    check("err_sticky", 32'(err), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
